// File: rtl/shot_pixel_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : court_pkg
// Description : Shared colours, frame-tick position and ball state encoding
//               for the basketball court pixel generator.
// Revision    : 1.0 - initial release
// ============================================================================
package court_pkg;

    localparam logic [2:0] C_BLACK = 3'b000;
    localparam logic [2:0] C_BALL  = 3'b110;
    localparam logic [2:0] C_RIM   = 3'b100;
    localparam logic [2:0] C_BOARD = 3'b111;
    localparam logic [2:0] C_FLOOR = 3'b011;
    localparam logic [2:0] C_SKY   = 3'b001;
    localparam logic [2:0] C_SCORE = 3'b010;

    // First pixel below the visible area: physics runs once per frame here
    localparam int C_TICK_ROW = 480;
    localparam int C_TICK_COL = 0;

    localparam int C_SCREEN_W = 640;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        SCORE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shot_pixel_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : shot_pixel_gen_if
// Description : Pixel stream, button inputs and colour/score outputs of the
//               court pixel generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface shot_pixel_gen_if;

    logic       p_tick;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       shoot;
    logic [2:0] sw;
    logic [2:0] rgb;
    logic [3:0] score;

    modport master (
        output p_tick, video_on, pixel_x, pixel_y, shoot, sw,
        input  rgb, score
    );

    modport slave (
        input  p_tick, video_on, pixel_x, pixel_y, shoot, sw,
        output rgb, score
    );

endinterface
`default_nettype wire

// File: rtl/shot_pixel_gen_physics.sv
`default_nettype none
// ============================================================================
// Module      : shot_physics
// Description : Once-per-frame projectile state machine: launch, gravity
//               flight, basket/miss detection and BCD basket counter.
// Revision    : 1.0 - initial release
// ============================================================================
import court_pkg::*;

module shot_physics #(
    parameter int BALL_X0    = 80,
    parameter int BALL_Y0    = 400,
    parameter int BALL_SIZE  = 8,
    parameter int HOOP_X_L   = 520,
    parameter int HOOP_X_R   = 560,
    parameter int HOOP_Y     = 200,
    parameter int FLOOR_Y    = 460,
    parameter int GRAVITY    = 1,
    parameter int SCORE_HOLD = 60
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_frame_tick,
    input  wire logic          i_shoot,
    input  wire logic [2:0]    i_sw,
    output logic [9:0]         o_bx,
    output logic signed [10:0] o_by,
    output state_t             o_state,
    output logic [3:0]         o_score
);

    localparam int HOLD_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

    localparam logic [9:0]          C_REST_X    = 10'(BALL_X0);
    localparam logic signed [10:0]  C_REST_Y    = 11'(BALL_Y0);
    localparam logic signed [10:0]  C_HOOP_Y    = 11'(HOOP_Y);
    localparam logic [10:0]         C_HOOP_L    = 11'(HOOP_X_L);
    localparam logic [10:0]         C_HOOP_R    = 11'(HOOP_X_R);
    localparam logic signed [10:0]  C_MISS_Y    = 11'(FLOOR_Y - BALL_SIZE);
    localparam logic [9:0]          C_MISS_X    = 10'(C_SCREEN_W);
    localparam logic [10:0]         C_HALF      = 11'(BALL_SIZE / 2);
    localparam logic [7:0]          C_GRAV      = 8'(GRAVITY);
    localparam logic [HOLD_W-1:0]   C_HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);

    state_t             r_state,  w_state_nx;
    logic               r_armed,  w_armed_nx;
    logic               r_shoot_d;
    logic [9:0]         r_bx,     w_bx_nx;
    logic signed [10:0] r_by,     w_by_nx;
    logic [3:0]         r_vx,     w_vx_nx;
    logic signed [7:0]  r_vy,     w_vy_nx;
    logic [HOLD_W-1:0]  r_hold,   w_hold_nx;
    logic [3:0]         r_score,  w_score_nx;

    logic               w_shoot_edge;
    logic [9:0]         w_bx_step;
    logic signed [10:0] w_by_step;
    logic signed [7:0]  w_vy_step;
    logic [10:0]        w_ball_cx;
    logic               w_score_hit;
    logic               w_miss;
    logic [3:0]         w_vx_launch;
    logic signed [7:0]  w_vy_launch;
    logic [3:0]         w_score_inc;

    assign w_shoot_edge = i_shoot & ~r_shoot_d;

    // One integration step, computed from the pre-tick position and velocity
    assign w_bx_step   = r_bx + {6'd0, r_vx};
    assign w_by_step   = r_by + {{3{r_vy[7]}}, r_vy};
    assign w_vy_step   = r_vy + C_GRAV;
    assign w_ball_cx   = {1'b0, w_bx_step} + C_HALF;

    assign w_score_hit = (r_by < C_HOOP_Y) && (w_by_step >= C_HOOP_Y)
                      && (w_ball_cx >= C_HOOP_L) && (w_ball_cx < C_HOOP_R);
    assign w_miss      = (w_by_step >= C_MISS_Y) || (w_bx_step >= C_MISS_X);

    assign w_vx_launch = 4'd3 + {1'b0, i_sw};
    assign w_vy_launch = 8'd0 - (8'd12 + {5'd0, i_sw});
    assign w_score_inc = (r_score == 4'd9) ? 4'd0 : r_score + 4'd1;

    always_comb begin
        w_state_nx = r_state;
        w_armed_nx = r_armed;
        w_bx_nx    = r_bx;
        w_by_nx    = r_by;
        w_vx_nx    = r_vx;
        w_vy_nx    = r_vy;
        w_hold_nx  = r_hold;
        w_score_nx = r_score;
        case (r_state)
            IDLE: begin
                w_bx_nx = C_REST_X;
                w_by_nx = C_REST_Y;
                if (i_frame_tick && r_armed) begin
                    w_state_nx = FLIGHT;
                    w_armed_nx = 1'b0;
                    w_vx_nx    = w_vx_launch;
                    w_vy_nx    = w_vy_launch;
                end else if (w_shoot_edge) begin
                    w_armed_nx = 1'b1;
                end
            end
            FLIGHT: begin
                if (i_frame_tick) begin
                    w_bx_nx = w_bx_step;
                    w_by_nx = w_by_step;
                    w_vy_nx = w_vy_step;
                    if (w_score_hit) begin
                        w_state_nx = SCORE;
                        w_hold_nx  = '0;
                        w_score_nx = w_score_inc;
                    end else if (w_miss) begin
                        w_state_nx = IDLE;
                        w_bx_nx    = C_REST_X;
                        w_by_nx    = C_REST_Y;
                    end
                end
            end
            SCORE: begin
                if (i_frame_tick) begin
                    if (r_hold == C_HOLD_LAST) begin
                        w_state_nx = IDLE;
                        w_hold_nx  = '0;
                        w_bx_nx    = C_REST_X;
                        w_by_nx    = C_REST_Y;
                    end else begin
                        w_hold_nx  = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_shoot_d <= 1'b0;
            r_bx      <= C_REST_X;
            r_by      <= C_REST_Y;
            r_vx      <= '0;
            r_vy      <= '0;
            r_hold    <= '0;
            r_score   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_armed   <= w_armed_nx;
            r_shoot_d <= i_shoot;
            r_bx      <= w_bx_nx;
            r_by      <= w_by_nx;
            r_vx      <= w_vx_nx;
            r_vy      <= w_vy_nx;
            r_hold    <= w_hold_nx;
            r_score   <= w_score_nx;
        end
    end

    assign o_bx    = r_bx;
    assign o_by    = r_by;
    assign o_state = r_state;
    assign o_score = r_score;

endmodule
`default_nettype wire

// File: rtl/shot_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : shot_pixel_gen
// Description : Court renderer downstream of vga_sync: frame-tick decode,
//               layered colour mux and registered rgb output.
// Revision    : 1.0 - initial release
// ============================================================================
import court_pkg::*;

module shot_pixel_gen #(
    parameter int BALL_X0    = 80,
    parameter int BALL_Y0    = 400,
    parameter int BALL_SIZE  = 8,
    parameter int HOOP_X_L   = 520,
    parameter int HOOP_X_R   = 560,
    parameter int HOOP_Y     = 200,
    parameter int FLOOR_Y    = 460,
    parameter int GRAVITY    = 1,
    parameter int SCORE_HOLD = 60
) (
    input  wire logic       clk,
    input  wire logic       reset,
    shot_pixel_gen_if.slave vga
);

    localparam logic [9:0] C_RIM_Y0   = 10'(HOOP_Y);
    localparam logic [9:0] C_RIM_Y1   = 10'(HOOP_Y + 3);
    localparam logic [9:0] C_RIM_X0   = 10'(HOOP_X_L);
    localparam logic [9:0] C_RIM_X1   = 10'(HOOP_X_R);
    localparam logic [9:0] C_BOARD_X1 = 10'(HOOP_X_R + 4);
    localparam logic [9:0] C_BOARD_Y0 = 10'(HOOP_Y - 40);
    localparam logic [9:0] C_FLOOR_Y  = 10'(FLOOR_Y);

    logic               w_frame_tick;
    logic [9:0]         w_bx;
    logic signed [10:0] w_by;
    state_t             w_state;
    logic [3:0]         w_score;

    logic signed [11:0] w_px;
    logic signed [11:0] w_py;
    logic signed [11:0] w_ball_x0;
    logic signed [11:0] w_ball_x1;
    logic signed [11:0] w_ball_y0;
    logic signed [11:0] w_ball_y1;
    logic               w_in_ball;
    logic               w_in_rim;
    logic               w_in_board;
    logic               w_in_floor;
    logic [2:0]         w_colour;
    logic [2:0]         r_rgb;

    assign w_frame_tick = vga.p_tick
                       && (vga.pixel_x == 10'(C_TICK_COL))
                       && (vga.pixel_y == 10'(C_TICK_ROW));

    shot_physics #(
        .BALL_X0    (BALL_X0),
        .BALL_Y0    (BALL_Y0),
        .BALL_SIZE  (BALL_SIZE),
        .HOOP_X_L   (HOOP_X_L),
        .HOOP_X_R   (HOOP_X_R),
        .HOOP_Y     (HOOP_Y),
        .FLOOR_Y    (FLOOR_Y),
        .GRAVITY    (GRAVITY),
        .SCORE_HOLD (SCORE_HOLD)
    ) u_physics (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (w_frame_tick),
        .i_shoot      (vga.shoot),
        .i_sw         (vga.sw),
        .o_bx         (w_bx),
        .o_by         (w_by),
        .o_state      (w_state),
        .o_score      (w_score)
    );

    // Signed compares so a ball partly above row 0 still draws its visible rows
    assign w_px      = {2'b00, vga.pixel_x};
    assign w_py      = {2'b00, vga.pixel_y};
    assign w_ball_x0 = {2'b00, w_bx};
    assign w_ball_x1 = w_ball_x0 + 12'(BALL_SIZE);
    assign w_ball_y0 = {w_by[10], w_by};
    assign w_ball_y1 = w_ball_y0 + 12'(BALL_SIZE);

    assign w_in_ball  = (w_px >= w_ball_x0) && (w_px < w_ball_x1)
                     && (w_py >= w_ball_y0) && (w_py < w_ball_y1);
    assign w_in_rim   = (vga.pixel_y >= C_RIM_Y0) && (vga.pixel_y < C_RIM_Y1)
                     && (vga.pixel_x >= C_RIM_X0) && (vga.pixel_x < C_RIM_X1);
    assign w_in_board = (vga.pixel_x >= C_RIM_X1) && (vga.pixel_x < C_BOARD_X1)
                     && (vga.pixel_y >= C_BOARD_Y0) && (vga.pixel_y < C_RIM_Y1);
    assign w_in_floor = (vga.pixel_y >= C_FLOOR_Y);

    always_comb begin
        w_colour = C_SKY;
        if (!vga.video_on) begin
            w_colour = C_BLACK;
        end else if (w_in_ball) begin
            w_colour = C_BALL;
        end else if (w_in_rim) begin
            w_colour = C_RIM;
        end else if (w_in_board) begin
            w_colour = C_BOARD;
        end else if (w_in_floor) begin
            w_colour = C_FLOOR;
        end else if (w_state == SCORE) begin
            w_colour = C_SCORE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= C_BLACK;
        end else if (vga.p_tick) begin
            r_rgb <= w_colour;
        end
    end

    assign vga.rgb   = r_rgb;
    assign vga.score = w_score;

endmodule
`default_nettype wire

// File: tb/tb_shot_pixel_gen.sv
`default_nettype none
// Bench for shot_pixel_gen: two instances (default court and a low hoop that
// a sw=0 shot sinks) checked against an integer trajectory model.
module tb_shot_pixel_gen;

    localparam int M_IDLE   = 0;
    localparam int M_FLIGHT = 1;
    localparam int M_SCORE  = 2;

    typedef struct packed {
        logic [2:0] rgb;
        logic [3:0] score;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    shot_pixel_gen_if if_def();
    shot_pixel_gen_if if_sc();

    shot_pixel_gen u_def (
        .clk   (clk),
        .reset (rst),
        .vga   (if_def)
    );

    shot_pixel_gen #(
        .HOOP_Y   (345),
        .HOOP_X_L (136),
        .HOOP_X_R (152)
    ) u_sc (
        .clk   (clk),
        .reset (rst),
        .vga   (if_sc)
    );

    // Reference model state, index 0 = default court, 1 = low hoop
    int m_state [2];
    int m_armed [2];
    int m_bx    [2];
    int m_by    [2];
    int m_vx    [2];
    int m_vy    [2];
    int m_hold  [2];
    int m_score [2];
    int hoop_y  [2] = '{200, 345};
    int hoop_l  [2] = '{520, 136};
    int hoop_r  [2] = '{560, 152};
    int m_shoot_prev = 0;
    int cur_sw = 0;
    bit cur_pt = 1'b0;

    exp_t q_def [$];
    exp_t q_sc  [$];
    exp_t last_def;
    exp_t last_sc;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pend     = 1'b0;
    bit   rst_d    = 1'b1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_colour(input int k, input int x, input int y, input bit von);
        if (!von) return 0;
        if (x >= m_bx[k] && x < m_bx[k] + 8 && y >= m_by[k] && y < m_by[k] + 8) return 6;
        if (y >= hoop_y[k] && y < hoop_y[k] + 3 && x >= hoop_l[k] && x < hoop_r[k]) return 4;
        if (x >= hoop_r[k] && x < hoop_r[k] + 4 && y >= hoop_y[k] - 40 && y < hoop_y[k] + 3) return 7;
        if (y >= 460) return 3;
        return (m_state[k] == M_SCORE) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE;
            m_armed[k] = 0;
            m_bx[k]    = 80;
            m_by[k]    = 400;
            m_vx[k]    = 0;
            m_vy[k]    = 0;
            m_hold[k]  = 0;
            m_score[k] = 0;
        end
        m_shoot_prev = 0;
    endtask

    task automatic model_frame(input int k);
        int nbx;
        int nby;
        if (m_state[k] == M_IDLE) begin
            if (m_armed[k] != 0) begin
                m_vx[k]    = 3 + cur_sw;
                m_vy[k]    = -(12 + cur_sw);
                m_armed[k] = 0;
                m_state[k] = M_FLIGHT;
            end
        end else if (m_state[k] == M_FLIGHT) begin
            nbx = m_bx[k] + m_vx[k];
            nby = m_by[k] + m_vy[k];
            m_vy[k] = m_vy[k] + 1;
            if (m_by[k] < hoop_y[k] && nby >= hoop_y[k] &&
                nbx + 4 >= hoop_l[k] && nbx + 4 < hoop_r[k]) begin
                m_score[k] = (m_score[k] + 1) % 10;
                m_state[k] = M_SCORE;
                m_hold[k]  = 0;
                m_bx[k]    = nbx;
                m_by[k]    = nby;
            end else if (nby >= 452 || nbx >= 640) begin
                m_state[k] = M_IDLE;
                m_bx[k]    = 80;
                m_by[k]    = 400;
            end else begin
                m_bx[k] = nbx;
                m_by[k] = nby;
            end
        end else begin
            m_hold[k] = m_hold[k] + 1;
            if (m_hold[k] == 60) begin
                m_state[k] = M_IDLE;
                m_hold[k]  = 0;
                m_bx[k]    = 80;
                m_by[k]    = 400;
            end
        end
    endtask

    task automatic cycle(input int x, input int y, input bit von, input bit pt, input bit sh);
        bit tick;
        bit edge_s;
        bit launch;
        int pre_state;
        int col [2];
        @(negedge clk);
        if_def.pixel_x = 10'(x);  if_sc.pixel_x = 10'(x);
        if_def.pixel_y = 10'(y);  if_sc.pixel_y = 10'(y);
        if_def.video_on = von;    if_sc.video_on = von;
        if_def.p_tick = pt;       if_sc.p_tick = pt;
        if_def.shoot = sh;        if_sc.shoot = sh;
        if_def.sw = 3'(cur_sw);   if_sc.sw = 3'(cur_sw);
        cur_pt = pt;
        tick   = pt && (x == 0) && (y == 480);
        edge_s = sh && (m_shoot_prev == 0);
        m_shoot_prev = sh ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            col[k]    = model_colour(k, x, y, von);
            pre_state = m_state[k];
            launch    = (pre_state == M_IDLE) && (m_armed[k] != 0) && tick;
            if (tick) model_frame(k);
            if (edge_s && pre_state == M_IDLE && !launch) m_armed[k] = 1;
        end
        if (pt) begin
            q_def.push_back('{rgb: 3'(col[0]), score: 4'(m_score[0])});
            q_sc.push_back('{rgb: 3'(col[1]), score: 4'(m_score[1])});
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        cur_pt = 1'b0;
        if_def.p_tick = 1'b0; if_sc.p_tick = 1'b0;
        if_def.shoot  = 1'b0; if_sc.shoot  = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int clip(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic probe_ball(input int k);
        int bx;
        int by;
        bx = m_bx[k];
        by = m_by[k];
        cycle(clip(bx, 1023),     clip(by, 1023),     1, 1, 0);
        cycle(clip(bx + 7, 1023), clip(by + 7, 1023), 1, 1, 0);
        cycle(clip(bx - 1, 1023), clip(by + 3, 1023), 1, 1, 0);
        cycle(clip(bx + 3, 1023), clip(by - 1, 1023), 1, 1, 0);
        cycle(clip(bx + 8, 1023), clip(by, 1023),     1, 1, 0);
        cycle(clip(bx, 1023),     clip(by + 8, 1023), 1, 1, 0);
    endtask

    task automatic random_probe(input bit pt);
        int x;
        int y;
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
        if (x == 0 && y == 480) y = 479;
        cycle(x, y, ($urandom_range(0, 7) != 0), pt, 0);
    endtask

    task automatic do_frame(input bit sh_tick, input bit rand_sw);
        probe_ball(0);
        probe_ball(1);
        random_probe(1);
        random_probe(1);
        random_probe(0);
        if (rand_sw) cur_sw = $urandom_range(0, 7);
        cycle(0, 480, 1, 1, sh_tick);
    endtask

    task automatic press();
        cycle(300, 100, 1, 0, 1);
        cycle(300, 100, 1, 0, 0);
    endtask

    function automatic bit busy();
        return (m_state[0] != M_IDLE) || (m_state[1] != M_IDLE) ||
               (m_armed[0] != 0) || (m_armed[1] != 0);
    endfunction

    task automatic run_to_idle(input int max_frames);
        int frames;
        frames = 0;
        while (busy() && frames < max_frames) begin
            do_frame(0, 0);
            frames++;
        end
        n_checks++;
        if (busy()) begin
            n_fail++;
            $display("FAIL frame_budget: still busy after %0d frames", frames);
        end
    endtask

    task automatic shot(input bit sh_tick, input bit rand_sw);
        if (sh_tick) do_frame(1, rand_sw);
        else press();
        run_to_idle(200);
    endtask

    always @(posedge clk) begin
        pend  <= cur_pt;
        rst_d <= rst;
    end

    // Monitor: pop an expectation after every p_tick, otherwise outputs must hold
    always @(negedge clk) begin
        if (rst_d) begin
            last_def = '0;
            last_sc  = '0;
        end else if (pend) begin
            if (q_def.size() == 0 || q_sc.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: got empty queue required pending entry");
            end else begin
                last_def = q_def.pop_front();
                last_sc  = q_sc.pop_front();
            end
        end
        check("rgb_def",   {1'b0, if_def.rgb}, {1'b0, last_def.rgb});
        check("score_def", if_def.score,       last_def.score);
        check("rgb_sc",    {1'b0, if_sc.rgb},  {1'b0, last_sc.rgb});
        check("score_sc",  if_sc.score,        last_sc.score);
    end

    initial begin
        if_def.p_tick = 1'b0;   if_sc.p_tick = 1'b0;
        if_def.video_on = 1'b0; if_sc.video_on = 1'b0;
        if_def.pixel_x = '0;    if_sc.pixel_x = '0;
        if_def.pixel_y = '0;    if_sc.pixel_y = '0;
        if_def.shoot = 1'b0;    if_sc.shoot = 1'b0;
        if_def.sw = '0;         if_sc.sw = '0;
        model_reset();
        do_reset(2);

        // Idle court colours
        cycle(80, 400, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(600, 470, 1, 1, 0);
        cycle(520, 200, 1, 1, 0);
        cycle(80, 400, 0, 1, 0);
        cycle(150, 345, 1, 1, 0);
        cycle(560, 170, 1, 1, 0);

        // sw=0 shot with a second press mid-flight
        cur_sw = 0;
        press();
        repeat (5) do_frame(0, 0);
        press();
        run_to_idle(200);

        // Reset at flight tick 10, then a fresh launch
        press();
        repeat (11) do_frame(0, 0);
        do_reset(1);
        repeat (3) do_frame(0, 0);
        shot(0, 0);

        // Random power, some shoot edges coinciding with the frame tick
        repeat (4) begin
            cur_sw = $urandom_range(0, 7);
            shot(1'($urandom_range(0, 1)), 1);
        end

        // Ten baskets on the low hoop walk the score through its wrap
        cur_sw = 0;
        repeat (10) shot(0, 0);

        cycle(10, 10, 1, 0, 0);
        cycle(10, 10, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
